// File: rtl/mac_stream_pkg.sv
// mac_stream_pkg
// Shared types and constants for the MAC operand streamer.
//   state_t      : streamer FSM states
//   DATA_W       : operand element width
//   ACC_W        : MAC accumulator / result width
//   DEF_DEPTH    : default buffer depth (elements per vector)
//   DEF_MAC_LAT  : default latency from last operand pair to final acc
package mac_stream_pkg;

  localparam int DATA_W      = 8;
  localparam int ACC_W       = 16;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_MAC_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    HOLD
  } state_t;

endpackage

// File: rtl/vec_operand_buf.sv
// vec_operand_buf
// Two DEPTH x DATA_W operand vectors (A and B) with one shared write port
// and two combinational read ports addressed by the same element index.
//   clk      : clock
//   wr_en    : write strobe (already qualified by the caller)
//   wr_sel   : 0 = vector A, 1 = vector B
//   wr_addr  : element index to write
//   wr_data  : element value
//   rd_idx   : element index to read from both vectors
//   rd_a     : A[rd_idx]
//   rd_b     : B[rd_idx]
module vec_operand_buf
  import mac_stream_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  // Contents survive reset; the host reloads only what it changes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) begin
        mem_b[wr_addr] <= wr_data;
      end else begin
        mem_a[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_a = mem_a[rd_idx];
  assign rd_b = mem_b[rd_idx];

endmodule

// File: rtl/mac_operand_streamer.sv
// mac_operand_streamer
// Feeds a pipelined MAC with a dot product of two buffered vectors.
// On start it pulses the MAC clear, streams one A/B pair per clock,
// drains the MAC pipeline, then holds the captured acc/of on a
// valid/ready result port until the consumer takes it.
//   clk       : clock, rising edge
//   r         : synchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data : host buffer write port (IDLE only)
//   len       : vector length, sampled with start (clamped to DEPTH)
//   start     : begin a dot product (honoured only in IDLE)
//   busy      : high whenever the FSM is not in IDLE
//   mac_r     : MAC clear (active-high)
//   mac_a/b   : operand pair to the MAC
//   mac_acc/of: accumulator and overflow flag from the MAC
//   res_valid/res_ready : result handshake
//   res_data/res_of     : captured dot product and overflow flag
module mac_operand_streamer
  import mac_stream_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = 3,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input  logic              clk,
  input  logic              r,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW:0]       len,
  input  logic              start,
  output logic              busy,
  output logic              mac_r,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  input  logic              mac_of,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_of
);

  localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
  localparam logic [DW-1:0] LAT_L   = DW'(MAC_LAT);

  state_t            state, state_n;
  logic [AW-1:0]     idx, idx_n;
  logic [AW:0]       len_q, len_n;
  logic [AW:0]       last_idx;
  logic [AW:0]       eff_len;
  logic [DW-1:0]     dcnt, dcnt_n;
  logic              busy_n, mac_r_n, res_valid_n, res_of_n;
  logic [DATA_W-1:0] mac_a_n, mac_b_n;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [ACC_W-1:0]  res_data_n;
  logic              buf_we;

  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  assign eff_len  = clamp_len(len);
  assign last_idx = len_q - ONE_L;
  // A write coinciding with start lands before the first read two edges later.
  assign buf_we   = wr_en && (state == IDLE);

  vec_operand_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (idx),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  // Outputs are registered from the current state, so each state's MAC
  // drive appears one cycle after the state is entered. DRAIN therefore
  // spans MAC_LAT+1 edges: MAC_LAT zero cycles plus the capture edge.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    len_n       = len_q;
    dcnt_n      = dcnt;
    busy_n      = busy;
    mac_r_n     = 1'b0;
    mac_a_n     = '0;
    mac_b_n     = '0;
    res_valid_n = res_valid;
    res_data_n  = res_data;
    res_of_n    = res_of;
    case (state)
      IDLE: begin
        if (start) begin
          busy_n = 1'b1;
          if (eff_len == '0) begin
            // Empty vector: result is zero, MAC is left alone.
            state_n     = HOLD;
            res_valid_n = 1'b1;
            res_data_n  = '0;
            res_of_n    = 1'b0;
          end else begin
            state_n = CLEAR;
            len_n   = eff_len;
          end
        end
      end
      CLEAR: begin
        mac_r_n = 1'b1;
        idx_n   = '0;
        state_n = STREAM;
      end
      STREAM: begin
        mac_a_n = rd_a;
        mac_b_n = rd_b;
        if ({1'b0, idx} == last_idx) begin
          dcnt_n  = '0;
          state_n = DRAIN;
        end else begin
          idx_n = idx + AW'(1);
        end
      end
      DRAIN: begin
        if (dcnt == LAT_L) begin
          res_data_n  = mac_acc;
          res_of_n    = mac_of;
          res_valid_n = 1'b1;
          state_n     = HOLD;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      mac_r     <= 1'b1;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_of    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      len_q     <= len_n;
      dcnt      <= dcnt_n;
      busy      <= busy_n;
      mac_r     <= mac_r_n;
      mac_a     <= mac_a_n;
      mac_b     <= mac_b_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      res_of    <= res_of_n;
    end
  end

endmodule

// File: tb/tb_mac_operand_streamer.sv
module tb_mac_operand_streamer;
  import mac_stream_pkg::*;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int MAC_LAT = 2;

  logic              clk = 1'b0;
  logic              r;
  logic              wr_en, wr_sel, start, res_ready;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [AW:0]       len;
  logic              busy, mac_r, res_valid, res_of;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic [ACC_W-1:0]  mac_acc, res_data;
  logic              mac_of;

  int checks = 0;
  int errors = 0;
  int am [DEPTH];
  int bm [DEPTH];

  always #5 clk = ~clk;

  mac_operand_streamer #(.DEPTH(DEPTH), .AW(AW), .MAC_LAT(MAC_LAT)) dut (
    .clk       (clk),
    .r         (r),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .start     (start),
    .busy      (busy),
    .mac_r     (mac_r),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_acc   (mac_acc),
    .mac_of    (mac_of),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_of    (res_of)
  );

  // Two-stage MAC stand-in: product register, then wrapping accumulator
  // with a sticky overflow flag; clear is synchronous on mac_r.
  logic [15:0] p_q, acc_q;
  logic        of_q;
  logic [16:0] sum_w;
  assign sum_w   = {1'b0, acc_q} + {1'b0, p_q};
  assign mac_acc = acc_q;
  assign mac_of  = of_q;
  always @(posedge clk) begin
    if (mac_r) begin
      p_q   <= '0;
      acc_q <= '0;
      of_q  <= 1'b0;
    end else begin
      p_q   <= 16'(mac_a) * 16'(mac_b);
      acc_q <= sum_w[15:0];
      of_q  <= of_q | sum_w[16];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wpair(input int i, input int a, input int b);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(i); wr_data = 8'(a);
    @(negedge clk);
    wr_sel = 1'b1; wr_data = 8'(b);
    @(negedge clk);
    wr_en = 1'b0;
    am[i] = a & 255;
    bm[i] = b & 255;
  endtask

  // One dot product from the start cycle through the result handshake.
  // Cycle c is the one beginning at the c-th edge after start is sampled.
  task automatic run(input int lreq, input int hold, input bit inject,
                     input bit coinc, input int cw, input string tag);
    int l, sum, ed, eo, last;
    l = (lreq > DEPTH) ? DEPTH : lreq;
    if (coinc) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'(cw);
      am[0] = cw & 255;
    end
    sum = 0;
    for (int i = 0; i < l; i++) sum += am[i] * bm[i];
    ed = sum % 65536;
    eo = (sum > 65535) ? 1 : 0;
    len = (AW+1)'(lreq);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    if (l == 0) begin
      chk({tag, " len0 valid"}, res_valid, 1);
      chk({tag, " len0 mac_r"}, mac_r, 0);
      chk({tag, " len0 busy"}, busy, 1);
    end else begin
      last = l + 2 + MAC_LAT;
      for (int c = 0; c <= last; c++) begin
        if (c > 0) @(negedge clk);
        if (inject && c == 3) begin
          wr_en = 1'b0; start = 1'b0;
        end
        chk({tag, " mac_r"}, mac_r, (c == 1) ? 1 : 0);
        chk({tag, " valid"}, res_valid, (c == last) ? 1 : 0);
        chk({tag, " busy"}, busy, 1);
        if (c >= 2 && c <= l + 1) begin
          chk({tag, " pair a"}, mac_a, am[c-2]);
          chk({tag, " pair b"}, mac_b, bm[c-2]);
        end else begin
          chk({tag, " zero a"}, mac_a, 0);
          chk({tag, " zero b"}, mac_b, 0);
        end
        if (inject && c == 2) begin
          wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0;
          wr_data = 8'(am[0] ^ 255); start = 1'b1; len = 1;
        end
      end
    end
    chk({tag, " res_data"}, res_data, ed);
    chk({tag, " res_of"}, res_of, eo);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, res_valid, 1);
      chk({tag, " hold data"}, res_data, ed);
      chk({tag, " hold of"}, res_of, eo);
      chk({tag, " hold mac_r"}, mac_r, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, " done valid"}, res_valid, 0);
    chk({tag, " done busy"}, busy, 0);
  endtask

  initial begin
    r = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; start = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin am[i] = 0; bm[i] = 0; end
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst mac_r", mac_r, 1);
    chk("rst mac_a", mac_a, 0);
    chk("rst mac_b", mac_b, 0);
    chk("rst valid", res_valid, 0);
    chk("rst data", res_data, 0);
    chk("rst of", res_of, 0);
    r = 1'b1;
    @(negedge clk);
    chk("idle mac_r", mac_r, 0);
    chk("idle busy", busy, 0);
    // Clear all buffer slots so later expectations never depend on X.
    for (int i = 0; i < DEPTH; i++) wpair(i, 0, 0);

    wpair(0, 6, 9); wpair(1, 5, 4); wpair(2, 9, 2); wpair(3, 3, 8);
    run(4, 0, 0, 0, 0, "dot4");

    wpair(0, 255, 255); wpair(1, 40, 40);
    run(2, 0, 0, 0, 0, "ovf");

    wpair(0, 6, 7); wpair(1, 5, 5); wpair(2, 3, 11);
    run(3, 5, 0, 0, 0, "hold5");
    run(3, 0, 0, 0, 0, "b2b");

    run(0, 1, 0, 0, 0, "len0");
    for (int i = 0; i < DEPTH; i++) wpair(i, $urandom_range(0, 255), $urandom_range(0, 255));
    run(9, 0, 0, 0, 0, "len9");

    wpair(0, 6, 9); wpair(1, 5, 4); wpair(2, 9, 2); wpair(3, 3, 8);
    run(4, 0, 1, 0, 0, "busyign");
    run(4, 0, 0, 0, 0, "afterign");

    // Abort in the middle of streaming.
    len = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    r = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort mac_r", mac_r, 1);
    chk("abort valid", res_valid, 0);
    chk("abort data", res_data, 0);
    chk("abort of", res_of, 0);
    chk("abort mac_a", mac_a, 0);
    r = 1'b1;
    @(negedge clk);
    chk("abort idle mac_r", mac_r, 0);
    run(4, 0, 0, 0, 0, "fresh");

    run(3, 0, 0, 1, 77, "coinc");

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 3) == 0) wpair(i, 255, 255 - $urandom_range(0, 3));
          else wpair(i, $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      run($urandom_range(0, 9), $urandom_range(0, 3), 1'b0,
          ($urandom_range(0, 3) == 0), $urandom_range(0, 255), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_streamer.md
Name: mac_operand_streamer

Overview:
Upstream feeder for pipelined_mac. It buffers two operand vectors (A, B) written by the host. On start, it clears the MAC, streams one A/B element pair per clock, then drains the MAC pipeline. It captures the final acc/of as a dot-product result and holds it on a valid/ready output until the result is taken.

Parameters:
DEPTH, 8, max vector length (elements per buffer)
AW, 3, buffer address width, clog2(DEPTH)
MAC_LAT, 2, cycles from last pair on mac_a/mac_b until mac_acc/mac_of are final

Ports:
clk  in  1  clock; all logic on rising edge
r  in  1  reset, synchronous, active-low
wr_en  in  1  buffer write strobe
wr_sel  in  1  0 = write buffer A, 1 = write buffer B
wr_addr  in  AW  element index
wr_data  in  8  element value, unsigned
len  in  AW+1  vector length, sampled with start
start  in  1  begin dot product (pulse)
busy  out  1  high in every state except IDLE
mac_r  out  1  to pipelined_mac r (active-high clear)
mac_a  out  8  to pipelined_mac a
mac_b  out  8  to pipelined_mac b
mac_acc  in  16  from pipelined_mac acc
mac_of  in  1  from pipelined_mac of
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  16  captured dot product, mod 2^16
res_of  out  1  captured overflow flag

Behaviour:
- All outputs are registered.
- Reset (r=0 at an edge) forces: state=IDLE, busy=0, mac_r=1, mac_a=0, mac_b=0, res_valid=0, res_data=0, res_of=0, counters=0. Buffer contents are not cleared.
- Reset mid-operation aborts immediately. Any pending result is discarded.
- In IDLE after reset, mac_r=0.
- Writes are accepted only in IDLE: mem[wr_sel][wr_addr] <= wr_data. Writes while busy are ignored.
- start is honoured only in IDLE. start while busy is ignored. If wr_en and start are high in the same cycle, the write lands first and the stream uses the new data.
- Effective length L = min(len, DEPTH).
- FSM states: IDLE, CLEAR, STREAM, DRAIN, HOLD.
- IDLE: if start and L=0, go to HOLD with res_data=0, res_of=0; the MAC is untouched. If start and L>0, latch L and go to CLEAR.
- CLEAR: exactly one cycle with mac_r=1, mac_a=mac_b=0. Then go to STREAM with idx=0.
- STREAM: mac_a=A[idx], mac_b=B[idx], mac_r=0, for L consecutive cycles with idx 0..L-1. When idx=L-1, go to DRAIN.
- DRAIN: mac_a=mac_b=0 for MAC_LAT cycles. At the edge ending the last drain cycle, capture res_data<=mac_acc and res_of<=mac_of. Then go to HOLD.
- HOLD: res_valid=1. res_data and res_of stay stable until a cycle with res_ready=1. On that handshake edge, res_valid<=0 and the FSM returns to IDLE. The next start is accepted from the following cycle. A res_ready asserted on the very first HOLD cycle completes the handshake.
- Timing, with start sampled at edge 0:
  - mac_r is high in cycle 1.
  - Pairs appear in cycles 2..L+1.
  - Zeros appear in cycles L+2..L+1+MAC_LAT.
  - res_valid rises at edge L+2+MAC_LAT.
- Arithmetic is done entirely in pipelined_mac. This block does no math and passes wrap-around and of through unchanged.

Decomposition:
- Package mac_stream_pkg holds:
  - state enum {IDLE, CLEAR, STREAM, DRAIN, HOLD}
  - DATA_W=8, ACC_W=16
  - the default DEPTH and MAC_LAT values
- One sub-module: vec_operand_buf. It holds two DEPTH x 8 register arrays with a single write port (sel/addr/data/en) and two combinational read ports indexed by idx.
- The FSM, counters and output registers live in the top module.

Test Plan:
- Reset, write A=[6,5,9,3], B=[9,4,2,8], len=4, start, res_ready=1 (bench instantiates the real pipelined_mac) -> mac_r high exactly 1 cycle; pairs (6,9)(5,4)(9,2)(3,8) in consecutive cycles; res_valid at start+4+MAC_LAT+2 edges; res_data=116, res_of=0.
- A=[255,40], B=[255,40], len=2 -> res_data=1089 (66625 mod 65536), res_of=1.
- A=[6,5,3], B=[7,5,11], len=3, res_ready held low 5 cycles -> res_valid and res_data=100 stable for all 5 cycles; returns to IDLE one cycle after res_ready=1; back-to-back second run gives 100, proving the MAC was cleared.
- start with len=0 -> no mac_r pulse, no pairs; res_valid next cycle with res_data=0, res_of=0. Then len=9 with DEPTH=8 -> exactly 8 pairs streamed.
- While busy: wr_en to A[0] and a second start -> both ignored; result unchanged (116 for the first vector set).
- r=0 during STREAM -> next edge: busy=0, mac_r=1, res_valid=0, res_data=0. A fresh start after reset completes normally with correct value.
